id_ex_stage: RTL and testbench

Execute-stage front end of the pipelined MIPS core. It registers the decoded instruction at the ID/EX boundary and generates the 4-bit ALU control code. It resolves EX/MEM and MEM/WB forwarding onto the two ALU operands and flags load-use hazards back to decode. Its `alu_ctl`, `alu_a` and `alu_b` outputs drive the ALU's `ctl`, `a` and `b` inputs directly.

---
 rtl/id_ex_stage.sv | 170 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode, operand forwarding and
// load-use hazard detection for the pipelined MIPS core.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   stall, flush              hold / bubble the ID/EX register
//   id_*                      decoded instruction from the ID stage
//   exmem_*, memwb_*          forwarding sources from later stages
//   alu_ctl, ex_wreg, ex_*    registered EX-stage control
//   alu_a, alu_b              forwarded ALU operands (combinational)
//   ex_store_data             forwarded rt value for stores (combinational)
//   load_use                  load-use hazard to decode (combinational)
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [1:0]  id_aluop,
    input  logic [5:0]  id_funct,
    input  logic        id_alusrc,
    input  logic        id_regdst,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_memwrite,
    input  logic        id_memtoreg,
    input  logic [31:0] id_rs_val,
    input  logic [31:0] id_rt_val,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        exmem_regwrite,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_regwrite,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic [3:0]  alu_ctl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_wreg,
    output logic        ex_valid,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic        ex_memtoreg,
    output logic        load_use
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CTL_W  = 4;

    logic [CTL_W-1:0]  r_alu_ctl;
    logic [REG_W-1:0]  r_wreg;
    logic              r_valid;
    logic              r_regwrite;
    logic              r_memread;
    logic              r_memwrite;
    logic              r_memtoreg;
    logic              r_alusrc;
    logic [DATA_W-1:0] r_rs_val;
    logic [DATA_W-1:0] r_rt_val;
    logic [DATA_W-1:0] r_imm;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;

    logic [CTL_W-1:0]  w_alu_ctl;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;

    // ALU control decode from operation class and funct
    always_comb begin
        w_alu_ctl = 4'b1111;
        case (id_aluop)
            2'b00: w_alu_ctl = 4'b0010;
            2'b01: w_alu_ctl = 4'b0110;
            2'b11: w_alu_ctl = 4'b0001;
            default: begin
                case (id_funct)
                    6'b100000, 6'b100001: w_alu_ctl = 4'b0010;
                    6'b100010, 6'b100011: w_alu_ctl = 4'b0110;
                    6'b100100:            w_alu_ctl = 4'b0000;
                    6'b100101:            w_alu_ctl = 4'b0001;
                    6'b101010:            w_alu_ctl = 4'b0111;
                    default:              w_alu_ctl = 4'b1111;
                endcase
            end
        endcase
    end

    // ID/EX register: rst > flush > stall > load
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_ctl  <= '0;
            r_wreg     <= '0;
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_alusrc   <= 1'b0;
            r_rs_val   <= '0;
            r_rt_val   <= '0;
            r_imm      <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
        end else if (flush) begin
            // Bubble: control cleared, data fields left as they are
            r_alu_ctl  <= '0;
            r_wreg     <= '0;
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
        end else if (!stall) begin
            r_alu_ctl  <= w_alu_ctl;
            r_wreg     <= id_regdst ? id_rd : id_rt;
            r_valid    <= id_valid;
            // An invalid slot carries no side effects downstream
            r_regwrite <= id_valid & id_regwrite;
            r_memread  <= id_valid & id_memread;
            r_memwrite <= id_valid & id_memwrite;
            r_memtoreg <= id_valid & id_memtoreg;
            r_alusrc   <= id_alusrc;
            r_rs_val   <= id_rs_val;
            r_rt_val   <= id_rt_val;
            r_imm      <= id_imm;
            r_rs       <= id_rs;
            r_rt       <= id_rt;
        end
    end

    // Forwarding: EX/MEM beats MEM/WB; register 0 is never forwarded
    always_comb begin
        w_fwd_rs = r_rs_val;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == r_rs))
            w_fwd_rs = exmem_result;
        else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == r_rs))
            w_fwd_rs = memwb_result;
    end

    always_comb begin
        w_fwd_rt = r_rt_val;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == r_rt))
            w_fwd_rt = exmem_result;
        else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == r_rt))
            w_fwd_rt = memwb_result;
    end

    assign alu_a         = w_fwd_rs;
    assign alu_b         = r_alusrc ? r_imm : w_fwd_rt;
    assign ex_store_data = w_fwd_rt;

    // Load in EX whose destination is read by the instruction in decode
    assign load_use = r_valid & r_memread & (r_wreg != '0) &
                      ((r_wreg == id_rs) | (r_wreg == id_rt));

    assign alu_ctl     = r_alu_ctl;
    assign ex_wreg     = r_wreg;
    assign ex_valid    = r_valid;
    assign ex_regwrite = r_regwrite;
    assign ex_memread  = r_memread;
    assign ex_memwrite = r_memwrite;
    assign ex_memtoreg = r_memtoreg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage with hand-computed expected values.
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [1:0]  id_aluop;
    logic [5:0]  id_funct;
    logic        id_alusrc;
    logic        id_regdst;
    logic        id_regwrite;
    logic        id_memread;
    logic        id_memwrite;
    logic        id_memtoreg;
    logic [31:0] id_rs_val;
    logic [31:0] id_rt_val;
    logic [31:0] id_imm;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        exmem_regwrite;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_regwrite;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_wreg;
    logic        ex_valid;
    logic        ex_regwrite;
    logic        ex_memread;
    logic        ex_memwrite;
    logic        ex_memtoreg;
    logic        load_use;

    int n_checks;
    int n_fail;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_aluop(id_aluop), .id_funct(id_funct),
        .id_alusrc(id_alusrc), .id_regdst(id_regdst),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
        .memwb_result(memwb_result),
        .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
        .ex_store_data(ex_store_data), .ex_wreg(ex_wreg),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_memtoreg(ex_memtoreg), .load_use(load_use)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; id_aluop = 2'b00; id_funct = '0;
        id_alusrc = 1'b0; id_regdst = 1'b0;
        id_regwrite = 1'b0; id_memread = 1'b0;
        id_memwrite = 1'b0; id_memtoreg = 1'b0;
        id_rs_val = '0; id_rt_val = '0; id_imm = '0;
        id_rs = '0; id_rt = '0; id_rd = '0;
        exmem_regwrite = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_regwrite = 1'b0; memwb_rd = '0; memwb_result = '0;
    endtask

    task automatic check_bubble(input string tag);
        check_eq({tag, "_ctl"},   32'(alu_ctl), 32'h0);
        check_eq({tag, "_valid"}, 32'(ex_valid), 32'h0);
        check_eq({tag, "_wreg"},  32'(ex_wreg), 32'h0);
        check_eq({tag, "_rw"},    32'(ex_regwrite), 32'h0);
        check_eq({tag, "_mr"},    32'(ex_memread), 32'h0);
        check_eq({tag, "_mw"},    32'(ex_memwrite), 32'h0);
        check_eq({tag, "_m2r"},   32'(ex_memtoreg), 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        idle_inputs();
        tick();
        rst = 1'b0;

        // Load a busy instruction, then reset with stall asserted
        id_valid = 1'b1; id_aluop = 2'b11; id_regdst = 1'b1; id_rd = 5'd9;
        id_regwrite = 1'b1; id_memread = 1'b1; id_memwrite = 1'b1;
        id_memtoreg = 1'b1;
        tick();
        check_eq("pre_rst_valid", 32'(ex_valid), 32'h1);
        rst = 1'b1; stall = 1'b1;
        tick();
        rst = 1'b0; stall = 1'b0;
        check_bubble("rst");

        // R-type slt
        idle_inputs();
        id_valid = 1'b1; id_aluop = 2'b10; id_funct = 6'b101010;
        id_rs_val = 32'd5; id_rt_val = 32'd9; id_regdst = 1'b1;
        id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd7; id_regwrite = 1'b1;
        tick();
        check_eq("slt_ctl",   32'(alu_ctl), 32'h7);
        check_eq("slt_a",     alu_a, 32'd5);
        check_eq("slt_b",     alu_b, 32'd9);
        check_eq("slt_wreg",  32'(ex_wreg), 32'd7);
        check_eq("slt_valid", 32'(ex_valid), 32'h1);
        check_eq("slt_rw",    32'(ex_regwrite), 32'h1);

        // Unknown funct, back-to-back
        id_funct = 6'b111111;
        tick();
        check_eq("bad_funct_ctl", 32'(alu_ctl), 32'hF);
        id_funct = 6'b100011;
        tick();
        check_eq("subu_ctl", 32'(alu_ctl), 32'h6);
        id_funct = 6'b100100;
        tick();
        check_eq("and_ctl", 32'(alu_ctl), 32'h0);
        id_funct = 6'b100101;
        tick();
        check_eq("or_funct_ctl", 32'(alu_ctl), 32'h1);
        id_funct = 6'b100001;
        tick();
        check_eq("addu_ctl", 32'(alu_ctl), 32'h2);
        id_aluop = 2'b01; id_regdst = 1'b0;
        tick();
        check_eq("sub_ctl",  32'(alu_ctl), 32'h6);
        check_eq("rt_wreg",  32'(ex_wreg), 32'd2);
        id_aluop = 2'b11;
        tick();
        check_eq("ori_ctl", 32'(alu_ctl), 32'h1);
        id_aluop = 2'b00;
        tick();
        check_eq("add_ctl", 32'(alu_ctl), 32'h2);

        // Forward priority on rs
        idle_inputs();
        id_valid = 1'b1; id_rs = 5'd3; id_rs_val = 32'h11;
        tick();
        exmem_regwrite = 1'b1; exmem_rd = 5'd3; exmem_result = 32'hAAAA;
        memwb_regwrite = 1'b1; memwb_rd = 5'd3; memwb_result = 32'hBBBB;
        #1;
        check_eq("fwd_exmem", alu_a, 32'hAAAA);
        exmem_regwrite = 1'b0;
        #1;
        check_eq("fwd_memwb", alu_a, 32'hBBBB);
        memwb_regwrite = 1'b0;
        #1;
        check_eq("fwd_none", alu_a, 32'h11);
        exmem_regwrite = 1'b1; exmem_rd = 5'd4;
        memwb_regwrite = 1'b1;
        #1;
        check_eq("fwd_rd_miss", alu_a, 32'hBBBB);

        // Register 0 is never forwarded
        id_rs = 5'd0; id_rs_val = 32'h22;
        tick();
        exmem_rd = 5'd0; memwb_rd = 5'd0;
        #1;
        check_eq("fwd_r0", alu_a, 32'h22);

        // Immediate select with forwarded rt
        idle_inputs();
        id_valid = 1'b1; id_alusrc = 1'b1; id_imm = 32'hFFFF_FFFC;
        id_rt = 5'd6; id_rt_val = 32'h55;
        tick();
        exmem_regwrite = 1'b1; exmem_rd = 5'd6; exmem_result = 32'h1234;
        #1;
        check_eq("imm_b",     alu_b, 32'hFFFF_FFFC);
        check_eq("imm_store", ex_store_data, 32'h1234);
        exmem_regwrite = 1'b0;
        #1;
        check_eq("imm_store_nofwd", ex_store_data, 32'h55);

        // rt forwarded onto alu_b when alusrc=0
        id_alusrc = 1'b0;
        tick();
        memwb_regwrite = 1'b1; memwb_rd = 5'd6; memwb_result = 32'h7777;
        #1;
        check_eq("rt_fwd_b", alu_b, 32'h7777);

        // Load-use detection
        idle_inputs();
        id_valid = 1'b1; id_memread = 1'b1; id_rt = 5'd4;
        tick();
        id_rs = 5'd9; id_rt = 5'd4;
        #1;
        check_eq("lu_rt", 32'(load_use), 32'h1);
        id_rs = 5'd4; id_rt = 5'd5;
        #1;
        check_eq("lu_rs", 32'(load_use), 32'h1);
        id_rs = 5'd8; id_rt = 5'd5;
        #1;
        check_eq("lu_none", 32'(load_use), 32'h0);
        id_rt = 5'd0;
        tick();
        check_eq("lu_wreg0", 32'(load_use), 32'h0);
        id_memread = 1'b0; id_rt = 5'd4;
        tick();
        check_eq("lu_nomemread", 32'(load_use), 32'h0);

        // Stall holds, then flush beats stall
        idle_inputs();
        id_valid = 1'b1; id_aluop = 2'b11; id_regdst = 1'b1; id_rd = 5'd8;
        id_regwrite = 1'b1; id_rs_val = 32'h99;
        tick();
        stall = 1'b1;
        id_aluop = 2'b01; id_rd = 5'd12; id_rs_val = 32'h1; id_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_ctl",   32'(alu_ctl), 32'h1);
            check_eq("stall_wreg",  32'(ex_wreg), 32'd8);
            check_eq("stall_valid", 32'(ex_valid), 32'h1);
            check_eq("stall_a",     alu_a, 32'h99);
        end
        flush = 1'b1;
        tick();
        stall = 1'b0; flush = 1'b0;
        check_bubble("flush");

        // id_valid=0 captures no control
        idle_inputs();
        id_valid = 1'b0; id_regwrite = 1'b1; id_memwrite = 1'b1;
        tick();
        check_eq("inv_valid", 32'(ex_valid), 32'h0);
        check_eq("inv_rw",    32'(ex_regwrite), 32'h0);
        check_eq("inv_mw",    32'(ex_memwrite), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
